// File: rtl/instr_seq_pkg.sv
// rtl/instr_seq_pkg.sv - shared state encoding and default widths for the instruction sequencer
package instr_seq_pkg;

    localparam int IP_WIDTH_DEF    = 12;
    localparam int STEP_WIDTH_DEF  = 16;
    localparam int PROGRAM_LEN_DEF = 3;
    localparam int MAX_STEPS_DEF   = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } instr_seq_state_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - issue/completion handshake between sequencer and execute datapath
interface instr_sequencer_if #(
    parameter int IP_WIDTH = instr_seq_pkg::IP_WIDTH_DEF
);

    logic                exec_valid;
    logic [IP_WIDTH-1:0] exec_ip;
    logic                exec_ready;
    logic                done_valid;
    logic [IP_WIDTH-1:0] next_ip;
    logic                halt;

    modport master (
        output exec_valid,
        output exec_ip,
        input  exec_ready,
        input  done_valid,
        input  next_ip,
        input  halt
    );

    modport slave (
        input  exec_valid,
        input  exec_ip,
        output exec_ready,
        output done_valid,
        output next_ip,
        output halt
    );

endinterface

// File: rtl/instr_seq_step_counter.sv
// rtl/instr_seq_step_counter.sv - saturating step counter; at_limit exists only with INSTR_SEQ_STEP_LIMIT_EN
module instr_seq_step_counter
    import instr_seq_pkg::*;
#(
    parameter int STEP_WIDTH = STEP_WIDTH_DEF,
    parameter int MAX_STEPS  = MAX_STEPS_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  incr,
    output logic [STEP_WIDTH-1:0] count
`ifdef INSTR_SEQ_STEP_LIMIT_EN
    ,
    output logic                  at_limit
`endif
);

    // A limit outside the counter range could never be reached.
    if (MAX_STEPS < 1 || 64'(MAX_STEPS) >= (64'd1 << STEP_WIDTH)) begin : g_bad_max_steps
        $error("instr_seq_step_counter: MAX_STEPS not representable in STEP_WIDTH bits");
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (incr && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

`ifdef INSTR_SEQ_STEP_LIMIT_EN
    assign at_limit = (count == MAX_STEPS[STEP_WIDTH-1:0]);
`endif

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - issues ips one at a time, counts steps, builds verdict; INSTR_SEQ_STEP_LIMIT_EN adds step limit
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int IP_WIDTH    = IP_WIDTH_DEF,
    parameter int STEP_WIDTH  = STEP_WIDTH_DEF,
    parameter int PROGRAM_LEN = PROGRAM_LEN_DEF,
    parameter int MAX_STEPS   = MAX_STEPS_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    check_pass,
    instr_sequencer_if.master       exec_bus,
    output logic [STEP_WIDTH-1:0]   steps,
    output logic                    finished,
    output logic                    success,
    output logic                    timeout
);

    // One extra bit so PROGRAM_LEN == 2**IP_WIDTH still compares correctly.
    localparam logic [IP_WIDTH:0] PROG_END = PROGRAM_LEN[IP_WIDTH:0];

    instr_seq_state_t    state;
    instr_seq_state_t    state_next;
    logic [IP_WIDTH-1:0] ip;
    logic                timeout_pending;
    logic                step_clear;
    logic                step_incr;
    logic                issue_valid;
    logic                limit_hit;
    logic                ip_out_of_range;
    logic                run_ends;

    instr_seq_step_counter #(
        .STEP_WIDTH (STEP_WIDTH),
        .MAX_STEPS  (MAX_STEPS)
    ) u_step_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (step_clear),
        .incr     (step_incr),
        .count    (steps)
`ifdef INSTR_SEQ_STEP_LIMIT_EN
        ,
        .at_limit (limit_hit)
`endif
    );

`ifndef INSTR_SEQ_STEP_LIMIT_EN
    assign limit_hit = 1'b0;
`endif

    assign ip_out_of_range = ({1'b0, exec_bus.next_ip} >= PROG_END);
    assign run_ends        = exec_bus.halt || ip_out_of_range || limit_hit;

    assign exec_bus.exec_valid = issue_valid;
    assign exec_bus.exec_ip    = ip;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        step_clear  = 1'b0;
        step_incr   = 1'b0;
        issue_valid = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    step_clear = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                issue_valid = 1'b1;
                if (exec_bus.exec_ready) begin
                    step_incr  = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (exec_bus.done_valid) begin
                    state_next = run_ends ? CHECK : ISSUE;
                end
            end
            CHECK:   state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // Timeout is latched at the final completion but published together with finished.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ip              <= '0;
            finished        <= 1'b0;
            success         <= 1'b0;
            timeout         <= 1'b0;
            timeout_pending <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        ip              <= '0;
                        finished        <= 1'b0;
                        success         <= 1'b0;
                        timeout         <= 1'b0;
                        timeout_pending <= 1'b0;
                    end
                end
                WAIT: begin
                    if (exec_bus.done_valid) begin
                        if (run_ends) begin
                            timeout_pending <= limit_hit && !exec_bus.halt && !ip_out_of_range;
                        end else begin
                            ip <= exec_bus.next_ip;
                        end
                    end
                end
                CHECK: begin
                    finished <= 1'b1;
                    success  <= check_pass && !timeout_pending;
                    timeout  <= timeout_pending;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Sequencer for generated FPGA test programs: issues instruction pointers one at a time to the instruction-execute datapath (local/heap memory, shift, out channel), waits for each instruction to complete, counts steps, and produces the `finished`/`success` verdict. It replaces free-running one-instruction-per-clock execution so that multi-cycle instructions (wide shifts, array moves) can stall without breaking step counting or the finish condition.

## Interface
Parameters:
- `IP_WIDTH`, 12, instruction pointer width
- `STEP_WIDTH`, 16, step counter width
- `PROGRAM_LEN`, 3, number of instructions; any ip >= this ends the program
- `MAX_STEPS`, 16, step limit (used only with `INSTR_SEQ_STEP_LIMIT_EN`)

Ports:
- `clock` in 1: single clock, all logic on rising edge
- `reset` in 1: synchronous, active-low; low on a rising edge resets the block
- `start` in 1: begin or restart a program run
- `exec_valid` out 1: instruction issue request
- `exec_ip` out IP_WIDTH: ip being issued
- `exec_ready` in 1: datapath accepts issue
- `done_valid` in 1: issued instruction completed
- `next_ip` in IP_WIDTH: successor ip, valid with `done_valid`
- `halt` in 1: program stop, valid with `done_valid`
- `check_pass` in 1: checker verdict on out channel
- `steps` out STEP_WIDTH: accepted issues this run
- `finished` out 1: run complete, held
- `success` out 1: verdict, valid while `finished`
- `timeout` out 1: run ended by step limit

## Operation
- States: IDLE, ISSUE, WAIT, CHECK, DONE.
- IDLE: all outputs 0. `start`=1 -> ISSUE with ip=0, steps=0.
- ISSUE: `exec_valid`=1, `exec_ip` stable until accepted. On `exec_valid && exec_ready`: steps+1, -> WAIT.
- WAIT: `exec_valid`=0. On `done_valid`: end if `halt`, or `next_ip` >= PROGRAM_LEN, or limit reached (with macro). Ending -> CHECK; otherwise ip=`next_ip`, -> ISSUE.
- CHECK (1 cycle): `success` <= `check_pass && !timeout`; `finished` <= 1; -> DONE.
- DONE: outputs held. `start`=1 clears `finished`, `success`, `timeout`, `steps` and goes to ISSUE with ip=0.
- `done_valid` is ignored outside WAIT. `start` is ignored in ISSUE, WAIT and CHECK.
- `steps` saturates at 2^STEP_WIDTH-1.
- ip width: `next_ip` is compared against PROGRAM_LEN unsigned at full IP_WIDTH.

## Timing
- Reset values: `exec_valid`=0, `exec_ip`=0, `steps`=0, `finished`=0, `success`=0, `timeout`=0; state IDLE.
- Reset low in any state, including mid-handshake, takes effect on that edge. An outstanding `done_valid` after reset is ignored.
- Start to first issue: `exec_valid` is high the cycle after `start` is sampled.
- Issue to WAIT: one cycle after acceptance. `done_valid` is legal from the cycle after acceptance onward.
- Completion to next issue: `exec_valid` is high the cycle after `done_valid`, so minimum throughput is one instruction per 2 cycles plus datapath latency.
- Final `done_valid` to `finished`: `finished`, `success` and `timeout` rise 2 cycles after the final `done_valid` (one cycle in CHECK, then DONE).

## Configuration
- Macro: `INSTR_SEQ_STEP_LIMIT_EN`.
- Defined: a `done_valid` in WAIT with `steps` == MAX_STEPS ends the run and sets `timeout`=1, unless `halt` or an out-of-range `next_ip` also ends it in that cycle, in which case `timeout`=0.
- Undefined: no limit; `timeout` is tied 0; MAX_STEPS is unused.

## Structure
- Package `instr_seq_pkg`: state enum `instr_seq_state_t` {IDLE, ISSUE, WAIT, CHECK, DONE} and default width constants.
- Sub-module `instr_seq_step_counter`: saturating step counter with clear, increment, and an `at_limit` compare against MAX_STEPS; `at_limit` is compiled out when the macro is undefined.

## Test plan
- Reset low for 2 cycles, then high -> all outputs 0; `exec_valid` stays 0 until `start`.
- PROGRAM_LEN=3, `exec_ready`=1, `done_valid` 1 cycle after each acceptance with `next_ip`=ip+1, `check_pass`=1 -> ips 0,1,2 issued; `steps`=3; `finished`=`success`=1 two cycles after the third done.
- `exec_ready` held low 3 cycles while ip=1 is issued -> `exec_valid`=1 and `exec_ip`=1 stable; `steps` stays 1 until acceptance.
- Macro defined, MAX_STEPS=5, `next_ip`=0 always, `check_pass`=1 -> ends after 5th done; `timeout`=1, `success`=0, `steps`=5.
- `halt`=1 with the done for ip 1 -> `finished`=1, `steps`=2, `timeout`=0, `success`=`check_pass`.
- Reset low while in WAIT with ip=2 -> next cycle all outputs 0. `start` then reissues ip=0 with `steps` restarting at 1.
